// File: rtl/bound_flasher_ctrl.sv
// rtl/bound_flasher_ctrl.sv - control FSM that sequences the bound-flasher lamp bar
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   flick      flick request, synchronous to clk
//   lamp       lamp vector the datapath registers at this edge
//   mode       datapath command: 0 clear, 1 shift-on, 2 shift-off
//   state_dbg  current state encoding
//   cycle_done one-clock pulse after a full sequence completes
`timescale 1ns/1ps
module bound_flasher_ctrl #(
    parameter int WIDTH   = 16,
    parameter int KICK_LO = 5,
    parameter int KICK_HI = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flick,
    input  logic [WIDTH-1:0] lamp,
    output logic [1:0]       mode,
    output logic [2:0]       state_dbg,
    output logic             cycle_done
);

    // Lamp masks: lamps 0..k lit.
    localparam logic [WIDTH-1:0] MASK_LO    = {{(WIDTH-KICK_LO-1){1'b0}}, {(KICK_LO+1){1'b1}}};
    localparam logic [WIDTH-1:0] MASK_LO_M1 = {{(WIDTH-KICK_LO){1'b0}}, {KICK_LO{1'b1}}};
    localparam logic [WIDTH-1:0] MASK_HI    = {{(WIDTH-KICK_HI-1){1'b0}}, {(KICK_HI+1){1'b1}}};
    localparam logic [WIDTH-1:0] MASK_FULL  = {WIDTH{1'b1}};

    typedef enum logic [2:0] {
        ST_INIT = 3'd0,
        ST_S1   = 3'd1,
        ST_S2   = 3'd2,
        ST_S3   = 3'd3,
        ST_S4   = 3'd4,
        ST_S5   = 3'd5,
        ST_S6   = 3'd6,
        ST_BAD  = 3'd7
    } state_t;

    state_t state;
    state_t state_next;
    logic   done_next;
    logic   done_q;

    logic at_lo;
    logic at_hi;

    assign at_lo = (lamp == MASK_LO);
    assign at_hi = (lamp == MASK_HI);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_INIT;
            done_q <= 1'b0;
        end else begin
            state  <= state_next;
            done_q <= done_next;
        end
    end

    // Transitions look at the lamp value being registered this edge, so the
    // new mode applies from the very next cycle and the bar stops exactly on
    // each target value.
    always_comb begin
        state_next = state;
        done_next  = 1'b0;
        case (state)
            ST_INIT: if (flick) state_next = ST_S1;
            ST_S1:   if (at_lo) state_next = ST_S2;
            ST_S2:   if (lamp == '0) state_next = ST_S3;
            ST_S3: begin
                // kickback wins over the normal exit at the upper mask
                if (flick && (at_lo || at_hi)) state_next = ST_S2;
                else if (at_hi)                state_next = ST_S4;
            end
            ST_S4:   if (lamp == MASK_LO_M1) state_next = ST_S5;
            ST_S5: begin
                if (flick && (at_lo || at_hi)) state_next = ST_S4;
                else if (lamp == MASK_FULL)    state_next = ST_S6;
            end
            ST_S6: begin
                if (lamp == '0) begin
                    state_next = ST_INIT;
                    done_next  = 1'b1;
                end
            end
            default: state_next = ST_INIT;
        endcase
    end

    // Moore outputs decoded from the state register only.
    always_comb begin
        mode = 2'd0;
        case (state)
            ST_S1, ST_S3, ST_S5: mode = 2'd1;
            ST_S2, ST_S4, ST_S6: mode = 2'd2;
            default:             mode = 2'd0;
        endcase
    end

    assign state_dbg  = state;
    assign cycle_done = done_q;

endmodule
